idli_dout_buf_m: RTL and testbench
==================================

// Module: idli_dout_buf_m
// PURPOSE
//  Output buffer directly downstream of the core's nibble output port
//  (o_core_dout/o_core_dout_vld/i_core_dout_acp). It queues nibbles in a
//  small FIFO and presents them off-chip on a 4-phase req/ack handshake.
//  The external ack is asynchronous to i_core_gck and is synchronised here.
//  Decouples core execution from slow external consumers.
// PARAMETERS
//  DEPTH        4  FIFO entries (nibbles), power of two, >= 2
//  SYNC_STAGES  2  flops in the i_buf_pin_ack synchroniser, >= 2
// PORTS
//  i_core_gck      in   1             core clock, rising edge
//  i_core_rst_n    in   1             reset, asynchronous, active-low
//  i_buf_data      in   4             nibble from core (o_core_dout)
//  i_buf_vld       in   1             nibble valid (o_core_dout_vld)
//  o_buf_acp       out  1             nibble accepted (to i_core_dout_acp)
//  o_buf_pin_data  out  4             nibble to pins, stable while req/ack busy
//  o_buf_pin_req   out  1             4-phase request to external consumer
//  i_buf_pin_ack   in   1             4-phase ack, asynchronous
//  o_buf_level     out  clog2(DEPTH)+1  entries held in FIFO (excl. pin reg)
//  o_buf_busy      out  1             pin handshake FSM not in IDLE
// BEHAVIOUR
//  Reset: FIFO empty, pointers 0, o_buf_pin_req=0, o_buf_pin_data=0,
//   o_buf_level=0, o_buf_busy=0, FSM=IDLE, synchroniser flops 0. Async
//   assert clears all immediately; contents/in-flight nibble discarded.
//  Core side: o_buf_acp = (level != DEPTH), from registered state only.
//   Push on rising edge when i_buf_vld & o_buf_acp. No push when full, even
//   if a pop occurs the same cycle. i_buf_data ignored when !i_buf_vld.
//  Pointers: clog2(DEPTH)+1 bits, wrap naturally; full = MSBs differ, rest
//   equal; empty = equal. Level = wr_ptr - rd_ptr (modulo width).
//  ack_s = i_buf_pin_ack after SYNC_STAGES flops.
//  FSM:
//   IDLE : if level!=0 & !ack_s -> load o_buf_pin_data <= head, pop,
//          o_buf_pin_req <= 1, go REQ. Else stay (waits for ack low after
//          reset with ack stuck high).
//   REQ  : hold req/data. If ack_s -> req <= 0, go ACKLO.
//   ACKLO: hold data. If !ack_s -> go IDLE.
//  Pop occurs on the IDLE->REQ edge; simultaneous push and pop permitted
//   (level unchanged). Push into empty FIFO on edge N -> req high after
//   edge N+1. Min ack-to-next-req = 2 edges after ack_s falls (ACKLO->IDLE
//   ->REQ).
//  o_buf_pin_data changes only on IDLE->REQ; never while req or ack_s high.
//  o_buf_busy = (FSM != IDLE). Order is strict FIFO; no nibble dropped or
//   duplicated.
// TESTING
//  1 Reset, ack=0: o_buf_acp=1, req=0, level=0, busy=0, pin_data=0.
//  2 Push 0xA with ack=0 -> req rises 2 edges after handshake, pin_data=0xA;
//    raise ack -> req falls SYNC_STAGES+1 edges later; drop ack -> IDLE.
//  3 Hold ack low-responder stalled; push 0x1..0x5 with DEPTH=4 -> first
//    nibble in pin reg, level=4, o_buf_acp=0 on 6th attempt; drain with
//    ack cycling -> pins show 1,2,3,4,5 in order.
//  4 Full FIFO, pop and push same cycle -> push refused that cycle, accepted
//    next; level never exceeds DEPTH.
//  5 Assert reset while req=1 and level=3 -> req=0, level=0 immediately;
//    release with ack still high -> no req until ack low synchronised.
//  6 Random vld and random-delay ack (async to gck), 1000 nibbles ->
//    scoreboard: output sequence equals input sequence, data stable in req.

Source files
------------

// File: rtl/idli_dout_buf_m.sv
// idli_dout_buf_m: output buffer behind the core's nibble output port.
// Nibbles from the core are queued in a small FIFO and then presented
// off-chip one at a time on a 4-phase req/ack handshake. The external ack
// is asynchronous to the core clock and passes through a flop synchroniser
// before the handshake FSM looks at it.
`timescale 1ns/1ps
module idli_dout_buf_m #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                     i_core_gck,
  input  logic                     i_core_rst_n,
  input  logic [3:0]               i_buf_data,
  input  logic                     i_buf_vld,
  output logic                     o_buf_acp,
  output logic [3:0]               o_buf_pin_data,
  output logic                     o_buf_pin_req,
  input  logic                     i_buf_pin_ack,
  output logic [$clog2(DEPTH):0]   o_buf_level,
  output logic                     o_buf_busy
);

  // Address bits index the storage; one extra pointer bit tells a full
  // FIFO apart from an empty one when the address bits match.
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    ACKLO = 2'd2
  } state_t;

  state_t               state;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        level;
  logic [3:0]           mem [DEPTH];
  logic [3:0]           head;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                 ack_s;
  logic                 full;
  logic                 empty;
  logic                 push;
  logic                 pop;

  // Occupancy derived purely from the registered pointers; the natural
  // wrap of the PW-bit subtraction gives the right answer in every case.
  assign level = wr_ptr - rd_ptr;
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Acceptance depends only on registered state, so a pop in the same
  // cycle never opens room for a push while the FIFO reads full.
  assign o_buf_acp   = !full;
  assign o_buf_level = level;

  assign push = i_buf_vld && !full;

  // A nibble leaves the FIFO only when the pin side is idle and the
  // consumer has visibly released ack from the previous transfer.
  assign pop  = (state == IDLE) && !empty && !ack_s;

  assign head  = mem[rd_ptr[AW-1:0]];
  assign ack_s = ack_sync[SYNC_STAGES-1];

  // Bring the asynchronous consumer ack into the core clock domain.
  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      ack_sync <= '0;
    end else begin
      ack_sync <= {ack_sync[SYNC_STAGES-2:0], i_buf_pin_ack};
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge i_core_gck) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= i_buf_data;
    end
  end

  // Write and read pointers; reset discards everything queued.
  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

  // Pin handshake: load and raise req from IDLE, drop req once ack is
  // seen, then wait for ack to fall before the next nibble may go out.
  // The pin data register is only written on the IDLE->REQ step, so it
  // stays put for the whole time req or ack is high.
  always_ff @(posedge i_core_gck or negedge i_core_rst_n) begin
    if (!i_core_rst_n) begin
      state          <= IDLE;
      o_buf_pin_req  <= 1'b0;
      o_buf_pin_data <= 4'h0;
      o_buf_busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            o_buf_pin_data <= head;
            o_buf_pin_req  <= 1'b1;
            o_buf_busy     <= 1'b1;
            state          <= REQ;
          end
        end
        REQ: begin
          if (ack_s) begin
            o_buf_pin_req <= 1'b0;
            state         <= ACKLO;
          end
        end
        ACKLO: begin
          if (!ack_s) begin
            o_buf_busy <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          o_buf_pin_req <= 1'b0;
          o_buf_busy    <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idli_dout_buf_m.sv
// Bench for idli_dout_buf_m: directed handshake/boundary scenarios plus a
// randomised run against a queue-based model of the buffer.
`timescale 1ns/1ps
module tb_idli_dout_buf_m;

  localparam int DEPTH = 4;
  localparam int SS    = 2;
  localparam int NRAND = 1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] data = 4'h0;
  logic       vld = 1'b0;
  logic       ack = 1'b0;
  logic       o_buf_acp;
  logic [3:0] o_buf_pin_data;
  logic       o_buf_pin_req;
  logic [2:0] o_buf_level;
  logic       o_buf_busy;

  idli_dout_buf_m #(.DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .i_core_gck     (clk),
    .i_core_rst_n   (rst_n),
    .i_buf_data     (data),
    .i_buf_vld      (vld),
    .o_buf_acp      (o_buf_acp),
    .o_buf_pin_data (o_buf_pin_data),
    .o_buf_pin_req  (o_buf_pin_req),
    .i_buf_pin_ack  (ack),
    .o_buf_level    (o_buf_level),
    .o_buf_busy     (o_buf_busy)
  );

  always #5 clk = ~clk;

  // Reference model state: queued nibbles, the nibble on the pins, whether a
  // request is outstanding, whether we still wait for ack to be released,
  // and the last SS clock samples of ack.
  logic [3:0]    q[$];
  logic [3:0]    sent[$];
  logic [3:0]    pdata_m = 4'h0;
  logic          req_m = 1'b0;
  logic          hold_m = 1'b0;
  logic [SS-1:0] sh_m = '0;
  logic          acks_m;
  logic          room_m;

  int n_chk  = 0;
  int n_pass = 0;
  int sb_idx = 0;
  logic       prev_req = 1'b0;
  logic [3:0] prev_pd = 4'h0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        q.delete();
        sent.delete();
        pdata_m = 4'h0;
        req_m   = 1'b0;
        hold_m  = 1'b0;
        sh_m    = '0;
      end else begin
        acks_m = sh_m[SS-1];
        room_m = (q.size() != DEPTH);
        if (!req_m && !hold_m) begin
          if (q.size() != 0 && !acks_m) begin
            pdata_m = q.pop_front();
            req_m   = 1'b1;
          end
        end else if (req_m) begin
          if (acks_m) begin
            req_m  = 1'b0;
            hold_m = 1'b1;
          end
        end else if (!acks_m) begin
          hold_m = 1'b0;
        end
        if (vld && room_m) begin
          q.push_back(data);
          sent.push_back(data);
        end
        sh_m = {sh_m[SS-2:0], ack};
      end
    end
  end

  function automatic void check(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  // One 4-phase transfer as an external consumer: wait req, take the data,
  // raise ack, wait req low, drop ack, wait for the buffer to go idle.
  task automatic hs(output logic [3:0] d);
    int g;
    g = 0;
    while (!o_buf_pin_req && g < 100) begin @(negedge clk); g++; end
    check("hs_req_seen", int'(o_buf_pin_req), 1);
    d = o_buf_pin_data;
    ack = 1'b1;
    g = 0;
    while (o_buf_pin_req && g < 100) begin @(negedge clk); g++; end
    check("hs_req_fall", int'(o_buf_pin_req), 0);
    ack = 1'b0;
    g = 0;
    while (o_buf_busy && g < 100) begin @(negedge clk); g++; end
    check("hs_idle", int'(o_buf_busy), 0);
  endtask

  logic [3:0] d;
  int base;
  int pushed;
  int g1;
  int g2;

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          check("acp",   int'(o_buf_acp), int'(q.size() != DEPTH));
          check("level", int'(o_buf_level), q.size());
          check("req",   int'(o_buf_pin_req), int'(req_m));
          check("busy",  int'(o_buf_busy), int'(req_m | hold_m));
          check("pdata", int'(o_buf_pin_data), int'(pdata_m));
          check("level_max", int'(int'(o_buf_level) <= DEPTH), 1);
          if (!rst_n) begin
            sb_idx   = 0;
            prev_req = 1'b0;
          end else begin
            if (o_buf_pin_req && !prev_req) begin
              check("sb_have", int'(sent.size() > sb_idx), 1);
              if (sent.size() > sb_idx)
                check("sb_order", int'(o_buf_pin_data), int'(sent[sb_idx]));
              sb_idx++;
            end
            if (o_buf_pin_req && prev_req)
              check("pin_stable", int'(o_buf_pin_data), int'(prev_pd));
            prev_req = o_buf_pin_req;
            prev_pd  = o_buf_pin_data;
          end
        end
      end
    join_none

    // Reset values with ack low
    repeat (2) @(negedge clk);
    check("t1_acp", int'(o_buf_acp), 1);
    check("t1_req", int'(o_buf_pin_req), 0);
    check("t1_level", int'(o_buf_level), 0);
    check("t1_busy", int'(o_buf_busy), 0);
    check("t1_pdata", int'(o_buf_pin_data), 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    @(negedge clk);

    // Single nibble: req two edges after the push, falls SS+1 edges after ack
    vld = 1'b1; data = 4'hA;
    @(negedge clk);
    vld = 1'b0;
    check("t2_req_early", int'(o_buf_pin_req), 0);
    @(negedge clk);
    check("t2_req_up", int'(o_buf_pin_req), 1);
    check("t2_pdata", int'(o_buf_pin_data), 10);
    ack = 1'b1;
    @(negedge clk); check("t2_req_hold1", int'(o_buf_pin_req), 1);
    @(negedge clk); check("t2_req_hold2", int'(o_buf_pin_req), 1);
    @(negedge clk); check("t2_req_fall", int'(o_buf_pin_req), 0);
    ack = 1'b0;
    @(negedge clk); check("t2_busy1", int'(o_buf_busy), 1);
    @(negedge clk); check("t2_busy2", int'(o_buf_busy), 1);
    @(negedge clk); check("t2_idle", int'(o_buf_busy), 0);
    check("t2_pdata_kept", int'(o_buf_pin_data), 10);

    // Stalled consumer: five pushes fill pin reg plus FIFO, sixth refused
    for (int k = 1; k <= 5; k++) begin
      vld = 1'b1; data = 4'(k);
      @(negedge clk);
    end
    data = 4'h6;
    check("t3_acp_full", int'(o_buf_acp), 0);
    check("t3_level4", int'(o_buf_level), 4);
    check("t3_pdata1", int'(o_buf_pin_data), 1);
    check("t3_req", int'(o_buf_pin_req), 1);

    // Pop while full with vld held: refused on the pop edge, taken next
    hs(d);
    check("t3_first", int'(d), 1);
    @(negedge clk);
    check("t4_pop_level", int'(o_buf_level), 3);
    check("t4_pop_acp", int'(o_buf_acp), 1);
    @(negedge clk);
    check("t4_push_level", int'(o_buf_level), 4);
    check("t4_push_acp", int'(o_buf_acp), 0);
    vld = 1'b0;
    for (int k = 0; k < 5; k++) begin
      hs(d);
      check("t3_order", int'(d), k + 2);
    end
    check("t3_drained", int'(o_buf_level), 0);

    // Reset during an active request with ack high on release
    for (int k = 7; k <= 10; k++) begin
      vld = 1'b1; data = 4'(k);
      @(negedge clk);
    end
    vld = 1'b0;
    check("t5_req_pre", int'(o_buf_pin_req), 1);
    check("t5_level_pre", int'(o_buf_level), 3);
    ack = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("t5_req_rst", int'(o_buf_pin_req), 0);
    check("t5_level_rst", int'(o_buf_level), 0);
    check("t5_busy_rst", int'(o_buf_busy), 0);
    check("t5_pdata_rst", int'(o_buf_pin_data), 0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(negedge clk);
    vld = 1'b1; data = 4'hC;
    @(negedge clk);
    vld = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t5_no_req", int'(o_buf_pin_req), 0);
    end
    check("t5_level1", int'(o_buf_level), 1);
    ack = 1'b0;
    hs(d);
    check("t5_data", int'(d), 12);

    // Random valid pattern against a consumer with random ack delays
    base = sb_idx;
    pushed = 0; g1 = 0; g2 = 0;
    fork
      begin
        while (pushed < NRAND && g1 < 40000) begin
          @(negedge clk); g1++;
          vld  = ($urandom_range(0, 2) != 0);
          data = 4'($urandom_range(0, 15));
          if (vld && o_buf_acp) pushed++;
        end
        @(negedge clk);
        vld = 1'b0;
      end
      begin
        while ((sb_idx - base) < NRAND && g2 < 40000) begin
          @(negedge clk); g2++;
          if (o_buf_pin_req) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #($urandom_range(1, 4)) ack = 1'b1;
            while (o_buf_pin_req && g2 < 40000) begin @(negedge clk); g2++; end
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #($urandom_range(1, 4)) ack = 1'b0;
          end
        end
      end
    join
    check("t6_pushed", pushed, NRAND);
    check("t6_received", sb_idx - base, NRAND);
    if (o_buf_pin_req) hs(d);
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
